stopwatch_mode_ctrl: RTL and testbench

- Upstream mode controller for the stopwatch datapath.
- Conditions the raw pause/clear buttons (synchronise plus debounce) and the adjust/select switches (synchronise only).
- Runs the 4-state mode FSM and drives the 2-bit `cur_state` bus into the stage that decodes counter-enable and blink-enable.
- Also issues a one-cycle clear pulse to the minute/second counters.

---
 rtl/stopwatch_mode_ctrl_pkg.sv | 33 +++
 rtl/stopwatch_mode_ctrl_btn_debounce.sv | 70 +++++++
 rtl/stopwatch_mode_ctrl.sv | 104 ++++++++++
 tb/tb_stopwatch_mode_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_mode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_mode_ctrl_pkg
//  Purpose  : Mode encodings shared by the stopwatch mode controller and the
//             downstream counter-enable / blink-enable decoder. Both sides
//             import these codes, so the 2-bit encoding lives in one place.
//  Contents : mode_e     - 2-bit mode code (NORMAL/PAUSED/ADJMIN/ADJSEC)
//             next_mode  - mode selection from switches and pause request
//  Revision : 1.0 - initial release
// ============================================================================
package stopwatch_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      PAUSED = 2'b01,
      ADJMIN = 2'b10,
      ADJSEC = 2'b11
   } mode_e;

   // Adjust switch has priority; outside adjust the stored pause request
   // decides between running and paused.
   function automatic mode_e next_mode(input logic adj, input logic sel, input logic paused);
      mode_e m;
      if (adj) begin
         m = sel ? ADJSEC : ADJMIN;
      end else begin
         m = paused ? PAUSED : NORMAL;
      end
      return m;
   endfunction

endpackage : stopwatch_mode_ctrl_pkg
`default_nettype wire

// File: rtl/stopwatch_mode_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : Two-flop synchroniser, counter debounce and rising-edge pulse
//             for one raw push button.
//  Ports    : clk      in   system clock
//             rst      in   synchronous active-high reset
//             btn_raw  in   raw asynchronous bouncing button (active-high)
//             rise     out  one-cycle pulse per accepted press
//  Params   : DEBOUNCE_CYCLES - consecutive disagreeing cycles to accept a
//                               new level; CNT_W must satisfy
//                               2**CNT_W > DEBOUNCE_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q,      s1_d;
   logic             s2_q,      s2_d;
   logic             lvl_q,     lvl_d;      // accepted (debounced) level
   logic             lvl_dly_q, lvl_dly_d;  // accepted level one cycle late
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   always_comb begin
      s1_d      = btn_raw;
      s2_d      = s1_q;
      lvl_d     = lvl_q;
      lvl_dly_d = lvl_q;
      cnt_d     = '0;
      // Count only while the synchronised input disagrees with the accepted
      // level; any cycle of agreement restarts the qualification.
      if (s2_q != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d = s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         lvl_q     <= 1'b0;
         lvl_dly_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_dly_d;
         cnt_q     <= cnt_d;
      end
   end

   // Press only; a release produces no pulse.
   assign rise = lvl_q & ~lvl_dly_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/stopwatch_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_mode_ctrl
//  Purpose  : Upstream mode controller for the stopwatch datapath. Conditions
//             the pause/clear buttons and the adjust/select switches, runs
//             the 4-state mode FSM and strobes the counter clear.
//  Ports    : clk          in   system clock
//             rst          in   synchronous active-high reset
//             btn_pause    in   raw pause button (active-high, bouncing)
//             btn_clear    in   raw clear button (active-high, bouncing)
//             sw_adj       in   raw adjust switch (1 = adjust)
//             sw_sel       in   raw select switch (0 = minutes, 1 = seconds)
//             cur_state    out  mode code, see stopwatch_mode_ctrl_pkg
//             clear_pulse  out  one-cycle counter clear strobe
//             pause_flag   out  stored pause request (debug / LED)
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_mode_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_pause,
   input  logic       btn_clear,
   input  logic       sw_adj,
   input  logic       sw_sel,
   output logic [1:0] cur_state,
   output logic       clear_pulse,
   output logic       pause_flag
);

   import stopwatch_mode_ctrl_pkg::*;

   logic  adj_s1_q, adj_s1_d;
   logic  adj_s2_q, adj_s2_d;
   logic  sel_s1_q, sel_s1_d;
   logic  sel_s2_q, sel_s2_d;
   logic  pause_flag_q,  pause_flag_d;
   logic  clear_pulse_q, clear_pulse_d;
   mode_e state_q, state_d;

   logic  pause_rise;
   logic  clear_rise;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_pause_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_pause),
      .rise    (pause_rise)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_clear_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clear),
      .rise    (clear_rise)
   );

   always_comb begin
      adj_s1_d      = sw_adj;
      adj_s2_d      = adj_s1_q;
      sel_s1_d      = sw_sel;
      sel_s2_d      = sel_s1_q;
      clear_pulse_d = clear_rise;
      // A pause press arriving while adjusting is dropped, not deferred.
      pause_flag_d  = pause_flag_q ^ (pause_rise & ~adj_s2_q);
      // Using the next pause flag lets the mode move on the same edge that
      // toggles the flag.
      state_d       = next_mode(adj_s2_q, sel_s2_q, pause_flag_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         adj_s1_q      <= 1'b0;
         adj_s2_q      <= 1'b0;
         sel_s1_q      <= 1'b0;
         sel_s2_q      <= 1'b0;
         pause_flag_q  <= 1'b0;
         clear_pulse_q <= 1'b0;
         state_q       <= NORMAL;
      end else begin
         adj_s1_q      <= adj_s1_d;
         adj_s2_q      <= adj_s2_d;
         sel_s1_q      <= sel_s1_d;
         sel_s2_q      <= sel_s2_d;
         pause_flag_q  <= pause_flag_d;
         clear_pulse_q <= clear_pulse_d;
         state_q       <= state_d;
      end
   end

   assign cur_state   = state_q;
   assign clear_pulse = clear_pulse_q;
   assign pause_flag  = pause_flag_q;

endmodule : stopwatch_mode_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_mode_ctrl
//  Purpose  : Self-checking bench for stopwatch_mode_ctrl (DEBOUNCE_CYCLES=4).
//             Each scenario pushes its expected per-cycle outputs into a
//             scoreboard queue, then drives stimulus and pops/compares on
//             every falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_mode_ctrl;

   import stopwatch_mode_ctrl_pkg::*;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_pause;
   logic       btn_clear;
   logic       sw_adj;
   logic       sw_sel;
   logic [1:0] cur_state;
   logic       clear_pulse;
   logic       pause_flag;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // rising edges seen so far

   typedef struct {
      int         due;
      logic [1:0] st;
      logic       clr;
      logic       pf;
   } exp_t;

   exp_t sb[$];

   stopwatch_mode_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_pause   (btn_pause),
      .btn_clear   (btn_clear),
      .sw_adj      (sw_adj),
      .sw_sel      (sw_sel),
      .cur_state   (cur_state),
      .clear_pulse (clear_pulse),
      .pause_flag  (pause_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Reset held 3 cycles with every input high, released, then inputs dropped.
   // Adjust is active by the time the pause press qualifies, so it is dropped.
   task automatic test_reset();
      exp_t e;
      int   t0;
      t0 = cyc;
      for (int i = 1; i <= 27; i++) begin
         e.due = t0 + i;
         e.st  = (i >= 6 && i < 18) ? ADJMIN : NORMAL;
         e.clr = (i == 10);
         e.pf  = 1'b0;
         sb.push_back(e);
      end
      rst = 1'b1; btn_pause = 1'b1; btn_clear = 1'b1; sw_adj = 1'b1; sw_sel = 1'b0;
      for (int i = 1; i <= 27; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL reset cyc=%0d scoreboard empty", cyc);
         end else begin
            e = sb.pop_front(); checks++;
            if (e.due != cyc || cur_state !== e.st || clear_pulse !== e.clr || pause_flag !== e.pf) begin
               errors++;
               $display("FAIL reset cyc=%0d got st=%b clr=%b pf=%b want st=%b clr=%b pf=%b",
                        cyc, cur_state, clear_pulse, pause_flag, e.st, e.clr, e.pf);
            end
         end
         if (i == 3) rst = 1'b0;
         if (i == 15) begin btn_pause = 1'b0; btn_clear = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0; end
      end
   endtask

   // Press pause 10 cycles from NORMAL, release, re-press: 00 -> 01 -> 00.
   task automatic test_pause_press();
      exp_t e;
      int   t0;
      t0 = cyc;
      for (int i = 1; i <= 40; i++) begin
         e.due = t0 + i;
         e.pf  = (i >= 7 && i < 27);
         e.st  = e.pf ? PAUSED : NORMAL;
         e.clr = 1'b0;
         sb.push_back(e);
      end
      btn_pause = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL pause_press cyc=%0d scoreboard empty", cyc);
         end else begin
            e = sb.pop_front(); checks++;
            if (e.due != cyc || cur_state !== e.st || clear_pulse !== e.clr || pause_flag !== e.pf) begin
               errors++;
               $display("FAIL pause_press cyc=%0d got st=%b clr=%b pf=%b want st=%b clr=%b pf=%b",
                        cyc, cur_state, clear_pulse, pause_flag, e.st, e.clr, e.pf);
            end
         end
         if (i == 10 || i == 30) btn_pause = 1'b0;
         if (i == 20) btn_pause = 1'b1;
      end
   endtask

   // Bounce 1,0,1,0,1 one cycle each: never qualifies.
   task automatic test_bounce();
      exp_t e;
      int   t0;
      t0 = cyc;
      for (int i = 1; i <= 15; i++) begin
         e.due = t0 + i; e.st = NORMAL; e.clr = 1'b0; e.pf = 1'b0;
         sb.push_back(e);
      end
      btn_pause = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL bounce cyc=%0d scoreboard empty", cyc);
         end else begin
            e = sb.pop_front(); checks++;
            if (e.due != cyc || cur_state !== e.st || clear_pulse !== e.clr || pause_flag !== e.pf) begin
               errors++;
               $display("FAIL bounce cyc=%0d got st=%b clr=%b pf=%b want st=%b clr=%b pf=%b",
                        cyc, cur_state, clear_pulse, pause_flag, e.st, e.clr, e.pf);
            end
         end
         if (i <= 4) btn_pause = (i % 2 == 0);
         else        btn_pause = 1'b0;
      end
   endtask

   // Pause, then ADJSEC, ADJMIN, ignored pause press, leave adjust -> PAUSED.
   task automatic test_adjust();
      exp_t e;
      int   t0;
      t0 = cyc;
      for (int i = 1; i <= 60; i++) begin
         e.due = t0 + i;
         e.pf  = (i >= 7);
         if      (i < 7)  e.st = NORMAL;
         else if (i < 23) e.st = PAUSED;
         else if (i < 31) e.st = ADJSEC;
         else if (i < 57) e.st = ADJMIN;
         else             e.st = PAUSED;
         e.clr = 1'b0;
         sb.push_back(e);
      end
      btn_pause = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL adjust cyc=%0d scoreboard empty", cyc);
         end else begin
            e = sb.pop_front(); checks++;
            if (e.due != cyc || cur_state !== e.st || clear_pulse !== e.clr || pause_flag !== e.pf) begin
               errors++;
               $display("FAIL adjust cyc=%0d got st=%b clr=%b pf=%b want st=%b clr=%b pf=%b",
                        cyc, cur_state, clear_pulse, pause_flag, e.st, e.clr, e.pf);
            end
         end
         case (i)
            10: btn_pause = 1'b0;
            20: begin sw_adj = 1'b1; sw_sel = 1'b1; end
            28: sw_sel = 1'b0;
            34: btn_pause = 1'b1;
            44: btn_pause = 1'b0;
            54: sw_adj = 1'b0;
            default: ;
         endcase
      end
   endtask

   // Clear held 20 cycles in ADJSEC: one strobe, mode unchanged.
   task automatic test_clear();
      exp_t e;
      int   t0;
      t0 = cyc;
      for (int i = 1; i <= 50; i++) begin
         e.due = t0 + i;
         e.st  = (i >= 3 && i < 43) ? ADJSEC : PAUSED;
         e.clr = (i == 17);
         e.pf  = 1'b1;
         sb.push_back(e);
      end
      sw_adj = 1'b1; sw_sel = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL clear cyc=%0d scoreboard empty", cyc);
         end else begin
            e = sb.pop_front(); checks++;
            if (e.due != cyc || cur_state !== e.st || clear_pulse !== e.clr || pause_flag !== e.pf) begin
               errors++;
               $display("FAIL clear cyc=%0d got st=%b clr=%b pf=%b want st=%b clr=%b pf=%b",
                        cyc, cur_state, clear_pulse, pause_flag, e.st, e.clr, e.pf);
            end
         end
         if (i == 10) btn_clear = 1'b1;
         if (i == 30) btn_clear = 1'b0;
         if (i == 40) begin sw_adj = 1'b0; sw_sel = 1'b0; end
      end
   endtask

   // Reset during an in-flight press: count discarded, held button re-qualifies.
   task automatic test_reset_midpress();
      exp_t e;
      int   t0;
      t0 = cyc;
      for (int i = 1; i <= 25; i++) begin
         e.due = t0 + i;
         e.pf  = (i < 4 || i >= 12);
         e.st  = e.pf ? PAUSED : NORMAL;
         e.clr = 1'b0;
         sb.push_back(e);
      end
      btn_pause = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL reset_midpress cyc=%0d scoreboard empty", cyc);
         end else begin
            e = sb.pop_front(); checks++;
            if (e.due != cyc || cur_state !== e.st || clear_pulse !== e.clr || pause_flag !== e.pf) begin
               errors++;
               $display("FAIL reset_midpress cyc=%0d got st=%b clr=%b pf=%b want st=%b clr=%b pf=%b",
                        cyc, cur_state, clear_pulse, pause_flag, e.st, e.clr, e.pf);
            end
         end
         if (i == 3)  rst = 1'b1;
         if (i == 5)  rst = 1'b0;
         if (i == 15) btn_pause = 1'b0;
      end
   endtask

   // Pause+clear on the same cycle from NORMAL, then a pause rise that lands
   // on the cycle synced adjust goes high (adjust wins, pause dropped).
   task automatic test_back_to_back();
      exp_t e;
      int   t0;
      t0 = cyc;
      for (int i = 1; i <= 55; i++) begin
         e.due = t0 + i;
         e.pf  = (i >= 9);
         if      (i < 9)  e.st = NORMAL;
         else if (i < 32) e.st = PAUSED;
         else if (i < 48) e.st = ADJMIN;
         else             e.st = PAUSED;
         e.clr = (i == 9);
         sb.push_back(e);
      end
      rst = 1'b1;
      for (int i = 1; i <= 55; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL back_to_back cyc=%0d scoreboard empty", cyc);
         end else begin
            e = sb.pop_front(); checks++;
            if (e.due != cyc || cur_state !== e.st || clear_pulse !== e.clr || pause_flag !== e.pf) begin
               errors++;
               $display("FAIL back_to_back cyc=%0d got st=%b clr=%b pf=%b want st=%b clr=%b pf=%b",
                        cyc, cur_state, clear_pulse, pause_flag, e.st, e.clr, e.pf);
            end
         end
         case (i)
            2:  begin rst = 1'b0; btn_pause = 1'b1; btn_clear = 1'b1; end
            14: begin btn_pause = 1'b0; btn_clear = 1'b0; end
            25: btn_pause = 1'b1;
            29: begin sw_adj = 1'b1; sw_sel = 1'b0; end
            35: btn_pause = 1'b0;
            45: sw_adj = 1'b0;
            default: ;
         endcase
      end
   endtask

   initial begin
      rst = 1'b1; btn_pause = 1'b0; btn_clear = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
      test_reset();
      test_pause_press();
      test_bounce();
      test_adjust();
      test_clear();
      test_reset_midpress();
      test_back_to_back();
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_drain left=%0d", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_stopwatch_mode_ctrl
`default_nettype wire
